// File: rtl/frog_pkg.sv
// Shared definitions for the frog game: lives FSM states, default sizing
// and the lives-to-LED thermometer mapping.
package frog_pkg;

    // States of the lives manager FSM.
    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        GRACE     = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    // Lives loaded at power-up and on every reload.
    localparam int MAX_LIVES_DEF = 3;

    // System clock frequency; one second of grace at this rate by default.
    localparam int CLK_HZ = 25000000;

    // Thermometer code of the remaining lives: 3 -> 111, 2 -> 011, 1 -> 001, 0 -> 000.
    function automatic logic [2:0] lives_therm(input logic [1:0] n);
        logic [2:0] t;
        case (n)
            2'd3:    t = 3'b111;
            2'd2:    t = 3'b011;
            2'd1:    t = 3'b001;
            default: t = 3'b000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lives_manager_grace_timer.sv
// grace_timer: loadable down-counter that times the post-hit grace window.
// A load makes it active for exactly GRACE_CYCLES cycles; done pulses in the
// last active cycle. clear abandons a running window immediately.
module grace_timer
    import frog_pkg::*;
#(
    parameter int GRACE_CYCLES = CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    output logic active,
    output logic done
);

    localparam int GRACE_W = $clog2(GRACE_CYCLES + 1);
    localparam logic [GRACE_W-1:0] LOAD_VAL = GRACE_W'(GRACE_CYCLES - 1);

    logic [GRACE_W-1:0] count_q;
    logic [GRACE_W-1:0] count_d;
    logic               active_q;
    logic               active_d;

    // Next count: clear wins over load, then count down while active and drop
    // out of the active state on the cycle the count has reached zero.
    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        if (clear) begin
            count_d  = '0;
            active_d = 1'b0;
        end else if (load) begin
            count_d  = LOAD_VAL;
            active_d = 1'b1;
        end else if (active_q) begin
            if (count_q == '0) begin
                active_d = 1'b0;
            end else begin
                count_d = count_q - GRACE_W'(1);
            end
        end
    end

    // Counter and active flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign done   = active_q && (count_q == '0);

endmodule

// File: rtl/lives_manager.sv
// lives_manager: tracks the frog's remaining lives from collision events,
// runs a post-hit grace window and flags game over to the level counter.
// Optional macro LIVES_LED_EN adds the o_LED lives thermometer with a blinking
// top LED during the grace window.
module lives_manager
    import frog_pkg::*;
#(
    parameter int MAX_LIVES    = MAX_LIVES_DEF,
    parameter int GRACE_CYCLES = CLK_HZ
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       collision,
    input  logic       frog_at_top,
    input  logic       reset_lives,
    output logic [1:0] lives,
    output logic       reset_level,
    output logic       frog_hit,
    output logic       invulnerable
`ifdef LIVES_LED_EN
   ,output logic [2:0] o_LED
`endif
);

    localparam logic [1:0] FULL_LIVES = 2'(MAX_LIVES);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] lives_q;
    logic [1:0] lives_d;
    logic       reset_level_q;
    logic       reset_level_d;
    logic       frog_hit_q;
    logic       frog_hit_d;

    // Previous-cycle copy of collision, used only for rising-edge detection.
    logic       collision_dly_q;
    logic       hit_edge;

    logic       timer_load;
    logic       timer_clear;
    logic       timer_active;
    logic       timer_done;

    assign hit_edge = collision && !collision_dly_q;

    grace_timer #(
        .GRACE_CYCLES(GRACE_CYCLES)
    ) u_grace_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .load   (timer_load),
        .active (timer_active),
        .done   (timer_done)
    );

    // Lives FSM: reload beats everything, the goal row masks a same-cycle hit,
    // and a hit on the last life goes straight to game over without frog_hit.
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        reset_level_d = reset_level_q;
        frog_hit_d    = 1'b0;
        timer_load    = 1'b0;
        timer_clear   = 1'b0;

        if (reset_lives) begin
            state_d       = ALIVE;
            lives_d       = FULL_LIVES;
            reset_level_d = 1'b0;
            timer_clear   = 1'b1;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (hit_edge && !frog_at_top) begin
                        if (lives_q > 2'd1) begin
                            lives_d    = lives_q - 2'd1;
                            frog_hit_d = 1'b1;
                            timer_load = 1'b1;
                            state_d    = GRACE;
                        end else if (lives_q == 2'd1) begin
                            lives_d       = 2'd0;
                            reset_level_d = 1'b1;
                            state_d       = GAME_OVER;
                        end
                    end
                end
                GRACE: begin
                    if (timer_done) begin
                        state_d = ALIVE;
                    end
                end
                GAME_OVER: begin
                    lives_d       = 2'd0;
                    reset_level_d = 1'b1;
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    // State, lives, output and edge-detect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ALIVE;
            lives_q         <= FULL_LIVES;
            reset_level_q   <= 1'b0;
            frog_hit_q      <= 1'b0;
            collision_dly_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            reset_level_q   <= reset_level_d;
            frog_hit_q      <= frog_hit_d;
            collision_dly_q <= collision;
        end
    end

    assign lives        = lives_q;
    assign reset_level  = reset_level_q;
    assign frog_hit     = frog_hit_q;
    assign invulnerable = timer_active;

`ifdef LIVES_LED_EN
    localparam int LED_DIV_W = 23;

    logic [LED_DIV_W-1:0] div_q;
    logic [2:0]           led_q;
    logic [2:0]           led_d;

    // Free-running divider; its top bit flips every 2^22 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + LED_DIV_W'(1);
        end
    end

    // Thermometer of the next lives value, with the top lit LED blanked on
    // the off phase of the divider while the grace window is running.
    always_comb begin
        led_d = lives_therm(lives_d);
        if ((state_d == GRACE) && div_q[LED_DIV_W-1] && (lives_d != 2'd0)) begin
            led_d = lives_therm(lives_d - 2'd1);
        end
    end

    // LED output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= lives_therm(FULL_LIVES);
        end else begin
            led_q <= led_d;
        end
    end

    assign o_LED = led_q;
`endif

endmodule

// File: doc/lives_manager.md
Name: lives_manager

Overview:
Upstream stage of level_counter. Tracks the frog's remaining lives from collision events and drives the `lives[1:0]` and `reset_level` inputs that the level counter consumes. Runs a post-hit grace window so a single collision cannot drain several lives. Reloads lives when the level counter returns `reset_lives`.

Parameters:
- MAX_LIVES, 3, lives loaded at reset and on reload; legal range 1..3 (fits 2-bit `lives`).
- GRACE_CYCLES, 25000000, grace-window length in clk cycles (1 s at 25 MHz); must be >= 1.
- GRACE_W, $clog2(GRACE_CYCLES+1), grace counter width (derived localparam).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- collision  in  1  level from the car/frog overlap detector; may stay high for many cycles.
- frog_at_top  in  1  frog on the goal row (same signal the level counter uses).
- reset_lives  in  1  reload request from level_counter; held high one or more cycles.
- lives  out  2  remaining lives, registered.
- reset_level  out  1  game-over indication, registered; held high while in GAME_OVER.
- frog_hit  out  1  one-cycle pulse that sends the frog back to start after a non-fatal hit.
- invulnerable  out  1  high during the grace window, for a blink effect in the display.

Behaviour:
- Reset (async): `lives` = MAX_LIVES, state = ALIVE, grace counter = 0, `collision_d` = 0. `reset_level`, `frog_hit` and `invulnerable` are all 0.
- Edge detect: `hit_edge` = collision & ~collision_d. `collision_d` is registered every cycle in every state.
- All outputs are registered. Each takes its new value at the same edge that samples the event, so it is visible the following cycle.

States:
- ALIVE
  - On hit_edge with frog_at_top = 0 and lives > 1: decrement `lives`, pulse `frog_hit` for 1 cycle, load the grace counter with GRACE_CYCLES-1, go to GRACE.
  - On hit_edge with frog_at_top = 0 and lives == 1: set `lives` = 0, set `reset_level` = 1, go to GAME_OVER. `frog_hit` is not pulsed, because level_counter resets the frog.
  - On hit_edge with frog_at_top = 1: ignored. The goal has priority over a same-cycle collision.
- GRACE
  - `invulnerable` = 1 and collisions are ignored.
  - The counter decrements each cycle. When it reaches 0, go to ALIVE with `invulnerable` = 0 from the next cycle.
  - A collision still held high on exit is not counted; only a fresh rising edge costs a life.
- GAME_OVER
  - `lives` = 0 and `reset_level` = 1 are held; collisions are ignored.
  - Leaves only on reset_lives.
- `reset_lives` = 1 in any state has highest priority after reset:
  - `lives` = MAX_LIVES, state = ALIVE.
  - Grace counter cleared; `reset_level`, `invulnerable` and `frog_hit` = 0 at the next edge.
  - A same-cycle hit_edge is discarded.
  - While `reset_lives` stays high, the block remains in ALIVE with full lives and ignores collisions.
- `lives` never underflows: there is no decrement at 0 and no wrap.
- `frog_hit` never asserts on two consecutive cycles.

Optional Feature:
- Macro: LIVES_LED_EN.
- Defined: adds output `o_LED[2:0]`, a thermometer of lives (3 → 111, 2 → 011, 1 → 001, 0 → 000), registered. During GRACE the top lit LED toggles every 2^22 cycles using a free-running divider.
- Not defined: the port and the divider are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package `frog_pkg`:
  - state enum {ALIVE, GRACE, GAME_OVER}, 2 bits.
  - localparams MAX_LIVES_DEF = 3 and CLK_HZ = 25000000.
- One sub-module: `grace_timer`, a loadable down-counter with a `load` input, a `GRACE_CYCLES` parameter, an `active` output and a one-cycle `done` output. The FSM stays in lives_manager.

Test Plan:
1. Reset, then a 10-cycle collision pulse → lives 3→2 after the first edge, `frog_hit` high exactly 1 cycle, `invulnerable` high for GRACE_CYCLES cycles (GRACE_CYCLES = 16 in the bench), only one life lost.
2. Hits spaced beyond the grace window, three times → lives 3→2→1→0. `reset_level` rises with lives = 0 and stays high; there is no `frog_hit` on the third hit.
3. In GAME_OVER, pulse reset_lives for 1 cycle → next cycle lives = 3, `reset_level` = 0, state ALIVE; a following collision edge decrements to 2.
4. collision and frog_at_top rise in the same cycle → lives unchanged, no `frog_hit`.
5. collision held high through the end of grace → no further decrement. Dropping and re-raising collision → decrement occurs.
6. reset_lives and a collision edge in the same cycle, and async reset asserted mid-GRACE → lives = 3, state ALIVE, `invulnerable` = 0 immediately after reset. Rerun with LIVES_LED_EN to check `o_LED` = 111/011/001/000.
